racket_ctrl: RTL and testbench
==============================

// Module: racket_ctrl
// PURPOSE
//  Generates the up/down drive for one racket instance. Arbitrates between
//  player buttons and a built-in tracking AI, paced by a movement-tick prescaler.
//  Sits between the button inputs / ball logic and the racket position register.
//  Holds the racket during serve and falls back to AI after player inactivity.
// PARAMETERS
//  TICK_DIV   25000  clocks per movement tick (>=2)
//  IDLE_TICKS 3000   ticks with no button before AI takes over (>=1)
//  DEADBAND   8      AI dead zone in pixels, |error| <= DEADBAND -> no move
//  RACKET_H   40     racket height in pixels
//  Y_MAX      440    highest legal racket_y (top-edge coordinate)
// PORTS
//  clk        in   1   system clock
//  reset      in   1   synchronous, active-high reset
//  btn_up     in   1   player up button, level, already synchronised
//  btn_down   in   1   player down button, level, already synchronised
//  ball_y     in   10  ball centre Y
//  ball_toward in  1   1 = ball travelling toward this racket
//  racket_y   in   10  current racket top Y (fed back from racket register)
//  freeze     in   1   1 = serve/point pause, racket must not move
//  up         out  1   one-clock move-up pulse to racket
//  down       out  1   one-clock move-down pulse to racket
//  mode       out  2   00 HOLD, 01 HUMAN, 10 AI (11 never driven)
// BEHAVIOUR
//  Reset: state HOLD, mode=00, up=0, down=0, prescaler=0, idle count=0.
//  Prescaler: counts 0..TICK_DIV-1 and wraps; tick=1 on the count TICK_DIV-1.
//   Free-runs in every state, including HOLD; cleared only by reset.
//  up/down are registered: tick in cycle N -> pulse in cycle N+1, high exactly 1
//   clock. Zero otherwise. up and down are never high together.
//  FSM (priority top to bottom, evaluated every clock):
//   - freeze=1: next state HOLD, idle count cleared, no pulse from this cycle.
//   - HOLD: freeze=0 -> HUMAN.
//   - HUMAN: any btn high -> idle count cleared. On tick with no btn, idle += 1;
//     when idle reaches IDLE_TICKS -> AI, idle cleared. Idle saturates, no wrap.
//   - AI: btn_up|btn_down high in any cycle -> HUMAN next cycle, idle cleared;
//     that cycle's tick, if any, produces no AI move.
//  HUMAN move on tick: up = btn_up & ~btn_down; down = btn_down & ~btn_up;
//   both pressed -> no move.
//  AI move on tick: target = ball_toward ? ball_y : Y_MAX/2 + RACKET_H/2.
//   err = target - (racket_y + RACKET_H/2), 12-bit signed, no overflow possible.
//   err > DEADBAND -> down; err < -DEADBAND -> up; else none.
//  Limits (all modes): up suppressed if racket_y == 0; down suppressed if
//   racket_y >= Y_MAX. Suppressed move yields no pulse.
//  Reset mid-pulse: up/down drop to 0 on the reset clock edge.
// TESTING
//  T1 reset, TICK_DIV=4: freeze=0 -> mode 00 then 01 next clk; up=down=0 in reset.
//  T2 HUMAN, btn_up=1, racket_y=200 -> one up pulse each 4 clks, 1 clk after tick.
//  T3 both buttons, then racket_y=0 with btn_up -> no pulses; racket_y=440 with
//   btn_down -> no pulses.
//  T4 IDLE_TICKS=3, no buttons -> mode 10 after 3rd tick; ball_toward=1,
//   ball_y=300, racket_y=200 -> down pulses; ball_y=225 -> none (err=5).
//  T5 AI, ball_toward=0, racket_y=100 -> down pulses until racket_y centre
//   within 8 of 240; press btn_down -> mode 01 next clk.
//  T6 freeze=1 during AI tick -> no pulse, mode 00 next clk, idle count cleared.

Source files
------------

// File: rtl/racket_ctrl.sv
// rtl/racket_ctrl.sv - racket up/down drive: button/AI arbitration paced by a movement tick
module racket_ctrl #(
  parameter int TICK_DIV   = 25000,
  parameter int IDLE_TICKS = 3000,
  parameter int DEADBAND   = 8,
  parameter int RACKET_H   = 40,
  parameter int Y_MAX      = 440
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  input  logic [9:0] i_ball_y,
  input  logic       i_ball_toward,
  input  logic [9:0] i_racket_y,
  input  logic       i_freeze,
  output logic       o_up,
  output logic       o_down,
  output logic [1:0] o_mode
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int IW = $clog2(IDLE_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TICKS - 1);
  localparam logic [11:0] HALF_H      = 12'(RACKET_H / 2);
  localparam logic [11:0] REST_TARGET = 12'(Y_MAX / 2 + RACKET_H / 2);
  localparam logic signed [11:0] DB_POS = 12'(DEADBAND);
  localparam logic signed [11:0] DB_NEG = 12'(-DEADBAND);

  typedef enum logic [1:0] {
    S_HOLD  = 2'b00,
    S_HUMAN = 2'b01,
    S_AI    = 2'b10
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [IW-1:0]  r_idle;
  logic           r_up;
  logic           r_down;
  logic [1:0]     r_mode;

  logic               w_tick;
  logic               w_btn_any;
  logic               w_at_top;
  logic               w_at_bot;
  logic [11:0]        w_center;
  logic [11:0]        w_target;
  logic signed [11:0] w_err;
  logic               w_hum_up;
  logic               w_hum_down;
  logic               w_ai_up;
  logic               w_ai_down;

  assign w_tick    = (r_cnt == CNT_LAST);
  assign w_btn_any = i_btn_up | i_btn_down;
  assign w_at_top  = (i_racket_y == 10'd0);
  assign w_at_bot  = (i_racket_y >= 10'(Y_MAX));

  // Tracking error is measured from the racket centre; away-ball target is the court middle
  assign w_center = {2'b00, i_racket_y} + HALF_H;
  assign w_target = i_ball_toward ? {2'b00, i_ball_y} : REST_TARGET;
  assign w_err    = $signed(w_target - w_center);

  // Edge limits are folded into each candidate so a blocked move never pulses
  assign w_hum_up   = i_btn_up & ~i_btn_down & ~w_at_top;
  assign w_hum_down = i_btn_down & ~i_btn_up & ~w_at_bot;
  assign w_ai_up    = (w_err < DB_NEG) & ~w_at_top;
  assign w_ai_down  = (w_err > DB_POS) & ~w_at_bot;

  assign o_up   = r_up;
  assign o_down = r_down;
  assign o_mode = r_mode;

  // Movement prescaler: free-runs in every state, cleared only by reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Mode FSM with registered one-clock move pulses and mode output
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_HOLD;
      r_mode  <= S_HOLD;
      r_idle  <= '0;
      r_up    <= 1'b0;
      r_down  <= 1'b0;
    end else begin
      r_up   <= 1'b0;
      r_down <= 1'b0;
      if (i_freeze) begin
        r_state <= S_HOLD;
        r_mode  <= S_HOLD;
        r_idle  <= '0;
      end else begin
        case (r_state)
          S_HOLD: begin
            r_state <= S_HUMAN;
            r_mode  <= S_HUMAN;
          end
          S_HUMAN: begin
            if (w_btn_any) begin
              r_idle <= '0;
              if (w_tick) begin
                r_up   <= w_hum_up;
                r_down <= w_hum_down;
              end
            end else if (w_tick) begin
              if (r_idle >= IDLE_LAST) begin
                r_state <= S_AI;
                r_mode  <= S_AI;
                r_idle  <= '0;
              end else begin
                r_idle <= r_idle + 1'b1;
              end
            end
          end
          S_AI: begin
            if (w_btn_any) begin
              r_state <= S_HUMAN;
              r_mode  <= S_HUMAN;
              r_idle  <= '0;
            end else if (w_tick) begin
              r_up   <= w_ai_up;
              r_down <= w_ai_down;
            end
          end
          default: begin
            r_state <= S_HOLD;
            r_mode  <= S_HOLD;
            r_idle  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_racket_ctrl.sv
// tb/tb_racket_ctrl.sv - self-checking bench for racket_ctrl against a behavioural model
module tb_racket_ctrl;

  localparam int TD = 4;
  localparam int IT = 3;
  localparam int DB = 8;
  localparam int RH = 40;
  localparam int YM = 440;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic [9:0] ball_y = 10'd0;
  logic       ball_toward = 1'b0;
  logic [9:0] racket_y = 10'd200;
  logic       freeze = 1'b0;
  logic       up;
  logic       down;
  logic [1:0] mode;

  int checks = 0;
  int errors = 0;
  string phase = "init";
  bit track = 1'b0;
  int n_up = 0;
  int n_down = 0;

  // behavioural model state: mode as 0 hold / 1 human / 2 ai
  int m_cnt = 0;
  int m_mode = 0;
  int m_idle = 0;
  bit m_up = 1'b0;
  bit m_down = 1'b0;

  racket_ctrl #(
    .TICK_DIV(TD), .IDLE_TICKS(IT), .DEADBAND(DB), .RACKET_H(RH), .Y_MAX(YM)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_btn_up(btn_up), .i_btn_down(btn_down),
    .i_ball_y(ball_y), .i_ball_toward(ball_toward), .i_racket_y(racket_y),
    .i_freeze(freeze), .o_up(up), .o_down(down), .o_mode(mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // what the next clock edge should produce given the inputs now applied
  task automatic model_edge();
    bit tick;
    int dir;
    int tgt;
    int err;
    tick = (m_cnt == TD - 1);
    if (reset) begin
      m_cnt = 0; m_mode = 0; m_idle = 0; m_up = 0; m_down = 0;
      return;
    end
    m_cnt = (m_cnt + 1) % TD;
    dir = 0;
    if (freeze) begin
      m_mode = 0;
      m_idle = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (btn_up || btn_down) begin
        m_idle = 0;
        if (tick) dir = int'(btn_down) - int'(btn_up);
      end else if (tick) begin
        m_idle = m_idle + 1;
        if (m_idle >= IT) begin
          m_mode = 2;
          m_idle = 0;
        end
      end
    end else begin
      if (btn_up || btn_down) begin
        m_mode = 1;
        m_idle = 0;
      end else if (tick) begin
        tgt = ball_toward ? int'(ball_y) : YM / 2 + RH / 2;
        err = tgt - (int'(racket_y) + RH / 2);
        if (err > DB) dir = 1;
        else if (err < -DB) dir = -1;
      end
    end
    if (dir == -1 && racket_y == 0) dir = 0;
    if (dir == 1 && int'(racket_y) >= YM) dir = 0;
    m_up = (dir == -1);
    m_down = (dir == 1);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk({phase, "_up"}, int'(up), int'(m_up));
    chk({phase, "_down"}, int'(down), int'(m_down));
    chk({phase, "_mode"}, int'(mode), m_mode);
    n_up += int'(up);
    n_down += int'(down);
    if (track) racket_y = 10'(int'(racket_y) + int'(m_down) - int'(m_up));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // T1: reset holds outputs low and mode HOLD; release moves to HUMAN next clock
    phase = "t1_reset";
    reset = 1'b1;
    steps(3);
    chk("t1_mode_in_reset", int'(mode), 0);
    reset = 1'b0;
    step();
    chk("t1_mode_human", int'(mode), 1);

    // T2: held up button gives one pulse per tick period
    phase = "t2_human_up";
    racket_y = 10'd200;
    btn_up = 1'b1;
    steps(4);
    n_up = 0; n_down = 0;
    steps(12);
    chk("t2_up_count", n_up, 3);
    chk("t2_down_count", n_down, 0);

    // T3: both buttons, and edge limits, suppress all pulses
    phase = "t3_limits";
    n_up = 0; n_down = 0;
    btn_down = 1'b1;
    steps(8);
    btn_down = 1'b0;
    racket_y = 10'd0;
    steps(8);
    btn_up = 1'b0;
    btn_down = 1'b1;
    racket_y = 10'd440;
    steps(8);
    chk("t3_pulse_count", n_up + n_down, 0);
    btn_down = 1'b0;

    // T4: inactivity hands over to AI which tracks the incoming ball
    phase = "t4_ai";
    racket_y = 10'd200;
    ball_toward = 1'b1;
    ball_y = 10'd300;
    steps(14);
    chk("t4_mode_ai", int'(mode), 2);
    n_up = 0; n_down = 0;
    steps(8);
    chk("t4_down_count", n_down, 2);
    ball_y = 10'd225;
    n_up = 0; n_down = 0;
    steps(8);
    chk("t4_deadband_count", n_up + n_down, 0);

    // T5: ball away -> AI recentres the racket, then a button reclaims control
    phase = "t5_recentre";
    ball_toward = 1'b0;
    racket_y = 10'd100;
    track = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if (int'(racket_y) + RH / 2 >= 240 - DB && int'(racket_y) + RH / 2 <= 240 + DB) break;
      step();
    end
    chk("t5_centred", int'(int'(racket_y) + RH / 2 >= 240 - DB && int'(racket_y) + RH / 2 <= 240 + DB), 1);
    n_up = 0; n_down = 0;
    steps(8);
    chk("t5_settled_count", n_up + n_down, 0);
    track = 1'b0;
    btn_down = 1'b1;
    step();
    chk("t5_mode_human", int'(mode), 1);
    btn_down = 1'b0;

    // T6: freeze on an AI tick cancels the move and forces HOLD
    phase = "t6_freeze";
    racket_y = 10'd100;
    steps(14);
    chk("t6_mode_ai", int'(mode), 2);
    for (int i = 0; i < TD; i++) begin
      if (m_cnt == TD - 1) break;
      step();
    end
    freeze = 1'b1;
    step();
    chk("t6_no_up", int'(up), 0);
    chk("t6_no_down", int'(down), 0);
    chk("t6_mode_hold", int'(mode), 0);
    freeze = 1'b0;
    steps(9);
    chk("t6_idle_restarted", int'(mode), 1);

    // reset asserted while a pulse is high drops it on that edge
    phase = "rst_mid_pulse";
    btn_up = 1'b1;
    racket_y = 10'd200;
    for (int i = 0; i < TD; i++) begin
      if (m_cnt == TD - 1) break;
      step();
    end
    step();
    chk("rmp_pulse_high", int'(up), 1);
    reset = 1'b1;
    step();
    chk("rmp_pulse_dropped", int'(up), 0);
    reset = 1'b0;
    btn_up = 1'b0;

    // randomized stress against the model
    phase = "rand";
    for (int blk = 0; blk < 40; blk++) begin
      bit quiet;
      quiet = ($urandom_range(0, 2) == 0);
      ball_y = 10'($urandom_range(0, 479));
      ball_toward = 1'($urandom_range(0, 1));
      for (int i = 0; i < 48; i++) begin
        reset = ($urandom_range(0, 399) == 0);
        freeze = ($urandom_range(0, 59) == 0);
        if (quiet) begin
          btn_up = 1'b0;
          btn_down = 1'b0;
        end else if ($urandom_range(0, 7) == 0) begin
          btn_up = 1'($urandom_range(0, 1));
          btn_down = 1'($urandom_range(0, 1));
        end
        case ($urandom_range(0, 9))
          0: racket_y = 10'd0;
          1: racket_y = 10'(YM);
          default: racket_y = 10'($urandom_range(0, YM));
        endcase
        step();
      end
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
